// File: rtl/fp_cmp_pkg.sv
// Shared types and constants for the single-precision compare/select unit.
// Contents: opcode enum, operand class struct, width localparams and the
// canonical quiet NaN.
package fp_cmp_pkg;

    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_MAN_W = 23;
    localparam int unsigned FP_MAG_W = FP_EXP_W + FP_MAN_W;
    localparam int unsigned FP_W     = 1 + FP_MAG_W;

    // Opcodes 5..7 are reserved and produce a zero result.
    typedef enum logic [2:0] {
        OpFeq  = 3'd0,
        OpFlt  = 3'd1,
        OpFle  = 3'd2,
        OpFmin = 3'd3,
        OpFmax = 3'd4
    } fp_cmp_op_e;

    // Positive, exponent all-ones, only the mantissa MSB set.
    localparam logic [FP_W-1:0] CANON_NAN =
        {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};

    typedef struct packed {
        logic is_zero;
        logic is_nan;
        logic is_snan;
    } fp_class_t;

endpackage

// File: rtl/fp_mag_cmp.sv
// Combinational unsigned magnitude comparator.
// Ports:
//   a_i, b_i : W-bit unsigned magnitudes
//   lt_o     : a_i < b_i
//   eq_o     : a_i == b_i
//   gt_o     : a_i > b_i
// Operands are split into 2-bit groups scanned MSB first; a group only decides
// the result if every higher group compared equal.
module fp_mag_cmp
    import fp_cmp_pkg::*;
#(
    parameter int unsigned W = FP_MAG_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         lt_o,
    output logic         eq_o,
    output logic         gt_o
);

    localparam int unsigned NumGroups = (W + 1) / 2;
    localparam int unsigned PadW      = 2 * NumGroups;

    logic [PadW-1:0] pa;
    logic [PadW-1:0] pb;
    logic            higher_eq;

    // Zero-pad an odd width so every group is two bits wide.
    always_comb begin
        pa         = '0;
        pb         = '0;
        pa[W-1:0]  = a_i;
        pb[W-1:0]  = b_i;
    end

    always_comb begin
        lt_o      = 1'b0;
        gt_o      = 1'b0;
        higher_eq = 1'b1;
        for (int g = int'(NumGroups) - 1; g >= 0; g--) begin
            logic [1:0] ga;
            logic [1:0] gb;
            ga = pa[2*g +: 2];
            gb = pb[2*g +: 2];
            if (higher_eq) begin
                if (ga > gb) begin
                    gt_o = 1'b1;
                end else if (ga < gb) begin
                    lt_o = 1'b1;
                end
            end
            higher_eq = higher_eq & (ga == gb);
        end
        eq_o = higher_eq;
    end

endmodule

// File: rtl/fp_cmp_unit.sv
// Two-stage compare/select unit for FEQ.S, FLT.S, FLE.S, FMIN.S and FMAX.S.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   valid_i / ready_o : operation handshake from the issue stage
//   op_i, a_i, b_i    : opcode (fp_cmp_op_e) and operands rs1/rs2
//   valid_o / ready_i : result handshake to the writeback arbiter
//   result_o, nv_o    : integer 0/1 or selected FP value, invalid-op flag
// S1 holds the operation and derives operand classes plus the magnitude
// compare; S2 resolves signs, selects the result and drives the outputs.
module fp_cmp_unit
    import fp_cmp_pkg::*;
#(
    parameter int unsigned EXP_W = FP_EXP_W,
    parameter int unsigned MAN_W = FP_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2:0]             op_i,
    input  logic [EXP_W+MAN_W:0]   a_i,
    input  logic [EXP_W+MAN_W:0]   b_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [EXP_W+MAN_W:0]   result_o,
    output logic                   nv_o
);

    localparam int unsigned MagW = EXP_W + MAN_W;
    localparam int unsigned W    = MagW + 1;

    localparam logic [W-1:0] CanonNan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic fp_class_t classify(input logic [W-1:0] x);
        fp_class_t          c;
        logic [EXP_W-1:0]   e;
        logic [MAN_W-1:0]   m;
        e         = x[W-2 -: EXP_W];
        m         = x[MAN_W-1:0];
        c.is_zero = (e == '0) && (m == '0);
        c.is_nan  = (&e) && (|m);
        c.is_snan = c.is_nan && !m[MAN_W-1];
        return c;
    endfunction

    // Stage 1 state
    logic           s1_valid_q;
    logic [2:0]     s1_op_q;
    logic [W-1:0]   s1_a_q;
    logic [W-1:0]   s1_b_q;

    // Stage 2 state (drives the outputs directly)
    logic           s2_valid_q;
    logic [W-1:0]   s2_result_q;
    logic           s2_nv_q;
    logic [W-1:0]   s2_result_d;
    logic           s2_nv_d;

    logic           s2_advance;
    logic           s1_advance;

    fp_class_t      a_cls;
    fp_class_t      b_cls;
    logic           mag_lt;
    logic           mag_eq;
    logic           mag_gt;
    logic           ord_lt;
    logic           ord_eq;
    logic           ord_gt;
    logic           any_nan;
    logic           any_snan;
    logic           both_zero;
    logic           a_neg;
    logic           b_neg;

    // Handshake: no skid buffer, so ready_o depends combinationally on ready_i.
    assign s2_advance = !s2_valid_q || ready_i;
    assign s1_advance = s2_advance;
    assign ready_o    = !s1_valid_q || s1_advance;

    assign valid_o  = s2_valid_q;
    assign result_o = s2_result_q;
    assign nv_o     = s2_nv_q;

    // Stage 1: classification and unsigned magnitude compare of registered operands.
    assign a_cls     = classify(s1_a_q);
    assign b_cls     = classify(s1_b_q);
    assign any_nan   = a_cls.is_nan | b_cls.is_nan;
    assign any_snan  = a_cls.is_snan | b_cls.is_snan;
    assign both_zero = a_cls.is_zero & b_cls.is_zero;
    assign a_neg     = s1_a_q[W-1];
    assign b_neg     = s1_b_q[W-1];

    fp_mag_cmp #(
        .W (MagW)
    ) u_mag_cmp (
        .a_i  (s1_a_q[MagW-1:0]),
        .b_i  (s1_b_q[MagW-1:0]),
        .lt_o (mag_lt),
        .eq_o (mag_eq),
        .gt_o (mag_gt)
    );

    // Sign resolution; only meaningful when neither operand is NaN.
    always_comb begin
        ord_lt = 1'b0;
        ord_eq = 1'b0;
        ord_gt = 1'b0;
        if (both_zero) begin
            ord_eq = 1'b1;
        end else if (a_neg != b_neg) begin
            ord_lt = a_neg;
            ord_gt = b_neg;
        end else if (!a_neg) begin
            ord_lt = mag_lt;
            ord_eq = mag_eq;
            ord_gt = mag_gt;
        end else begin
            // Both negative: larger magnitude is the smaller value.
            ord_lt = mag_gt;
            ord_eq = mag_eq;
            ord_gt = mag_lt;
        end
    end

    // Stage 2 result selection.
    always_comb begin
        logic is_max;
        s2_result_d = '0;
        s2_nv_d     = 1'b0;
        is_max      = (s1_op_q == OpFmax);
        case (fp_cmp_op_e'(s1_op_q))
            OpFeq: begin
                s2_result_d[0] = ord_eq && !any_nan;
                s2_nv_d        = any_snan;
            end
            OpFlt: begin
                s2_result_d[0] = ord_lt && !any_nan;
                s2_nv_d        = any_nan;
            end
            OpFle: begin
                s2_result_d[0] = (ord_lt || ord_eq) && !any_nan;
                s2_nv_d        = any_nan;
            end
            OpFmin, OpFmax: begin
                s2_nv_d = any_snan;
                if (a_cls.is_nan && b_cls.is_nan) begin
                    s2_result_d = CanonNan;
                end else if (a_cls.is_nan) begin
                    s2_result_d = s1_b_q;
                end else if (b_cls.is_nan) begin
                    s2_result_d = s1_a_q;
                end else if (both_zero) begin
                    // Zero of either sign: min prefers -0, max prefers +0.
                    s2_result_d[W-1] = is_max ? (a_neg & b_neg) : (a_neg | b_neg);
                end else if (ord_lt) begin
                    s2_result_d = is_max ? s1_b_q : s1_a_q;
                end else if (ord_gt) begin
                    s2_result_d = is_max ? s1_a_q : s1_b_q;
                end else begin
                    s2_result_d = s1_a_q;
                end
            end
            default: begin
                s2_result_d = '0;
                s2_nv_d     = 1'b0;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_nv_q     <= 1'b0;
        end else begin
            if (ready_o) begin
                s1_valid_q <= valid_i;
            end
            if (s2_advance) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_q <= s2_result_d;
                    s2_nv_q     <= s2_nv_d;
                end
            end
        end
    end

    // Stage 1 payload; qualified by s1_valid_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (valid_i && ready_o) begin
            s1_op_q <= op_i;
            s1_a_q  <= a_i;
            s1_b_q  <= b_i;
        end
    end

endmodule

// File: tb/tb_fp_cmp_unit.sv
// Bench for fp_cmp_unit: directed and random operations with a queue-based
// scoreboard; a separate monitor pops expectations as results are accepted.
module tb_fp_cmp_unit;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        nv_o;

    int          n_cmp;
    int          n_fail;
    int          rdy_mode;       // 0: always ready, 1: random, 2: stalled
    logic [32:0] exp_q[$];       // {nv, result}

    fp_cmp_unit u_dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .nv_o     (nv_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (value-level) ----------------
    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic bit is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    function automatic real fval(input logic [31:0] x);
        int  e;
        real m;
        real v;
        e = int'(x[30:23]);
        m = real'(x[22:0]);
        if (e == 255)    v = 1.0e300;
        else if (e == 0) v = m * (2.0 ** real'(-149));
        else             v = (1.0 + m / 8388608.0) * (2.0 ** real'(e - 127));
        return x[31] ? -v : v;
    endfunction

    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        bit  nan_any;
        bit  snan_any;
        real va;
        real vb;
        logic [31:0] r;
        nan_any  = is_nan(a) || is_nan(b);
        snan_any = is_snan(a) || is_snan(b);
        va = fval(a);
        vb = fval(b);
        r  = 32'h0;
        case (op)
            3'd0: return {snan_any, 31'h0, !nan_any && (va == vb)};
            3'd1: return {nan_any, 31'h0, !nan_any && (va < vb)};
            3'd2: return {nan_any, 31'h0, !nan_any && (va <= vb)};
            3'd3, 3'd4: begin
                if (is_nan(a) && is_nan(b)) r = 32'h7FC00000;
                else if (is_nan(a))         r = b;
                else if (is_nan(b))         r = a;
                else if (va < vb)           r = (op == 3'd3) ? a : b;
                else if (va > vb)           r = (op == 3'd3) ? b : a;
                else if (va == 0.0) begin
                    if (op == 3'd3) r = a[31] ? a : b;
                    else            r = a[31] ? b : a;
                end else            r = a;
                return {snan_any, r};
            end
            default: return 33'h0;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 9))
            0: return {s, 31'h0};
            1: return {s, 8'hFF, 23'h0};
            2: return {s, 8'hFF, 1'b1, 22'($urandom)};
            3: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 32'h3FFFFF))};
            4: return {s, 8'h00, 23'($urandom)};
            5: return {s, 8'h7F, 23'h0};
            6: return {s, 8'h80, 23'($urandom_range(0, 3))};
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    // Entered and left at posedge+1; holds valid_i until accepted.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] exp);
        int waited;
        waited  = 0;
        valid_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        forever begin
            @(negedge clk);
            if (ready_o) begin
                exp_q.push_back(exp);
                break;
            end
            waited++;
            if (waited > 200) begin
                check("issue_timeout", 33'(waited), 33'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || valid_o) && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_remaining", 33'(exp_q.size()), 33'd0);
    endtask

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ($urandom_range(0, 3) != 0);
            default: ready_i = 1'b0;
        endcase
    end

    // ---------------- monitor ----------------
    initial begin
        logic        hold_valid;
        logic [32:0] hold_val;
        logic [32:0] e;
        hold_valid = 1'b0;
        hold_val   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_valid = 1'b0;
            end else begin
                if (hold_valid) begin
                    check("stall_valid_held", {32'h0, valid_o}, 33'd1);
                    check("stall_result_stable", {nv_o, result_o}, hold_val);
                end
                hold_valid = valid_o && !ready_i;
                hold_val   = {nv_o, result_o};
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", {nv_o, result_o}, 33'h1_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {nv_o, result_o}, e);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        n_cmp    = 0;
        n_fail   = 0;
        rdy_mode = 0;
        rst      = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        op_i     = 3'd0;
        a_i      = 32'h0;
        b_i      = 32'h0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid_o", {32'h0, valid_o}, 33'd0);
        check("reset_result_o", {1'b0, result_o}, 33'd0);
        check("reset_nv_o", {32'h0, nv_o}, 33'd0);
        check("reset_ready_o", {32'h0, ready_o}, 33'd1);
        @(posedge clk);
        #1;

        // Directed cases with hand-derived expectations.
        issue(3'd1, 32'hBF800000, 32'h3F800000, {1'b0, 32'h1});        // FLT -1 < 1
        issue(3'd2, 32'h3F800000, 32'hBF800000, {1'b0, 32'h0});        // FLE 1 <= -1
        issue(3'd0, 32'h80000000, 32'h00000000, {1'b0, 32'h1});        // FEQ -0 == +0
        issue(3'd1, 32'hC0000000, 32'hBF800000, {1'b0, 32'h1});        // FLT -2 < -1
        issue(3'd0, 32'h7FC00000, 32'h3F800000, {1'b0, 32'h0});        // FEQ qNaN
        issue(3'd1, 32'h7FC00000, 32'h3F800000, {1'b1, 32'h0});        // FLT qNaN
        issue(3'd0, 32'h7F800001, 32'h3F800000, {1'b1, 32'h0});        // FEQ sNaN
        issue(3'd3, 32'h80000000, 32'h00000000, {1'b0, 32'h80000000}); // FMIN -0,+0
        issue(3'd3, 32'h00000000, 32'h80000000, {1'b0, 32'h80000000}); // FMIN +0,-0
        issue(3'd4, 32'h80000000, 32'h00000000, {1'b0, 32'h00000000}); // FMAX -0,+0
        issue(3'd4, 32'h7FC00000, 32'h40000000, {1'b0, 32'h40000000}); // FMAX qNaN,2
        issue(3'd4, 32'h7F800001, 32'h7FC00000, {1'b1, 32'h7FC00000}); // FMAX both NaN
        issue(3'd3, 32'hC1200000, 32'h41200000, {1'b0, 32'hC1200000}); // FMIN -10,10
        issue(3'd4, 32'hC1200000, 32'hC0A00000, {1'b0, 32'hC0A00000}); // FMAX -10,-5
        issue(3'd7, 32'h3F800000, 32'h3F800000, {1'b0, 32'h0});        // reserved
        drain();

        // Random operations with random issue gaps and random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            ra  = rand_operand();
            case ($urandom_range(0, 5))
                0:       rb = ra;
                1:       rb = ra ^ 32'h80000000;
                default: rb = rand_operand();
            endcase
            rop = 3'($urandom_range(0, 7));
            issue(rop, ra, rb, model(rop, ra, rb));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rdy_mode = 0;
        drain();

        // Backpressure: four back-to-back ops into a stalled output.
        rdy_mode = 2;
        fork
            begin
                issue(3'd1, 32'h3F800000, 32'h40000000, model(3'd1, 32'h3F800000, 32'h40000000));
                issue(3'd3, 32'h40400000, 32'hC0400000, model(3'd3, 32'h40400000, 32'hC0400000));
                issue(3'd4, 32'h40400000, 32'hC0400000, model(3'd4, 32'h40400000, 32'hC0400000));
                issue(3'd0, 32'h41000000, 32'h41000000, model(3'd0, 32'h41000000, 32'h41000000));
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_ready_low", {32'h0, ready_o}, 33'd0);
                check("bp_valid_high", {32'h0, valid_o}, 33'd1);
                check("bp_queue_depth", 33'(exp_q.size()), 33'd2);
                @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // Reset with two ops in flight, then a reserved op at 2-cycle latency.
        issue(3'd4, 32'h3F800000, 32'h40000000, model(3'd4, 32'h3F800000, 32'h40000000));
        issue(3'd3, 32'h3F800000, 32'h40000000, model(3'd3, 32'h3F800000, 32'h40000000));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_valid_o", {32'h0, valid_o}, 33'd0);
        check("flush_result_o", {1'b0, result_o}, 33'd0);
        idle(5);
        issue(3'd6, 32'h7F800001, 32'h3F800000, 33'h0);
        @(negedge clk);
        check("latency_cycle1_valid", {32'h0, valid_o}, 33'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("latency_cycle2_valid", {32'h0, valid_o}, 33'd1);
        drain();
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_cmp_unit.md
Name: fp_cmp_unit

Overview:
- Pipelined single-precision compare/select unit for the RISC-V F datapath. Executes FEQ.S, FLT.S, FLE.S, FMIN.S and FMAX.S.
- Consumes the L/E/G result of a sign-magnitude comparison and turns it into an integer-register result (FEQ/FLT/FLE) or an FP-register result (FMIN/FMAX), plus the NV exception flag.
- Two-stage valid/ready pipeline between the FP issue stage and the writeback arbiter.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, mantissa width. Operand width is 1+EXP_W+MAN_W.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- valid_i  input  1  operation presented
- ready_o  output  1  unit accepts operation this cycle
- op_i  input  3  fp_cmp_op_e: FEQ=0, FLT=1, FLE=2, FMIN=3, FMAX=4; 5-7 reserved
- a_i  input  32  operand rs1
- b_i  input  32  operand rs2
- valid_o  output  1  result available
- ready_i  input  1  downstream accepts result
- result_o  output  32  FEQ/FLT/FLE: zero-extended 0/1; FMIN/FMAX: selected operand or canonical NaN
- nv_o  output  1  invalid-operation flag for this result

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: valid_o=0, result_o=0, nv_o=0. Both stage valids are cleared. ready_o=1 in the cycle after reset deasserts.
- Transfer rules:
  - Input transfer occurs when valid_i&&ready_o.
  - Output transfer occurs when valid_o&&ready_i.
  - Latency is exactly 2 cycles from input transfer to valid_o with no backpressure. Throughput is 1 op/cycle.
- Stage 1 (S1): registers op and operands. Produces:
  - Per-operand class: zero (exp=0, man=0), NaN (exp all-ones, man!=0), sNaN (NaN with man[MSB]=0).
  - Magnitude L/E/G over the low 31 bits, via sub-module fp_mag_cmp, unsigned.
- Stage 2 (S2): sign resolution and selection. Output registers are driven from S2.
- Stall rules:
  - S2 advances when !valid_o || ready_i.
  - S1 advances when S2 can accept.
  - ready_o = !s1_valid || s1_advance (combinational from ready_i; no skid buffer).
  - While valid_o&&!ready_i, result_o and nv_o hold stable.
- Ordering (neither operand NaN):
  - Both zero: equal regardless of sign.
  - Signs differ: negative < positive.
  - Both positive: use magnitude L/E/G.
  - Both negative: swap L and G.
- FEQ: result = equal. NaN present: result 0; nv=1 only if an sNaN is present.
- FLT: result = less. FLE: result = less||equal. For both, NaN present: result 0 and nv=1 (signalling compare).
- FMIN/FMAX:
  - Exactly one operand NaN: result = the other operand.
  - Both NaN: result = canonical NaN 0x7FC00000.
  - nv=1 if either operand is an sNaN.
  - Opposite-sign zeros: FMIN returns -0 (0x80000000), FMAX returns +0 (0x00000000).
  - Equal non-zero values: return a_i.
- Reserved op: result 0, nv 0. The op still flows through the pipeline and produces valid_o.
- Reset mid-operation: all in-flight ops are discarded. No valid_o appears for ops accepted before reset.
- Back-to-back with stalled output: at most 2 ops are held (S1, S2). ready_o=0 when both are full and ready_i=0.

Decomposition:
- Package fp_cmp_pkg:
  - fp_cmp_op_e enum.
  - CANON_NAN constant: sign 0, exponent all-ones, mantissa MSB only.
  - fp_class_t struct {is_zero, is_nan, is_snan}.
  - Width localparams derived from EXP_W/MAN_W.
- Sub-module fp_mag_cmp: combinational unsigned magnitude compare of width EXP_W+MAN_W, producing L, E, G. It uses the MSB-first 2-bit-group cascade: a group's greater/less counts only if all higher groups are equal. Instantiated once, in S1.

Test Plan:
- FLT a=0xBF800000 (-1.0), b=0x3F800000 (1.0) -> result 1, nv 0. FLE with operands swapped -> 0.
- FEQ a=0x80000000, b=0x00000000 -> 1, nv 0. FLT a=0xC0000000 (-2.0), b=0xBF800000 (-1.0) -> 1.
- NaN cases:
  - FEQ a=0x7FC00000 (qNaN), b=0x3F800000 -> 0, nv 0.
  - FLT same operands -> 0, nv 1.
  - FEQ a=0x7F800001 (sNaN) -> 0, nv 1.
- FMIN/FMAX cases:
  - FMIN(0x80000000, 0x00000000) -> 0x80000000.
  - FMAX(0x7FC00000, 0x40000000) -> 0x40000000, nv 0.
  - FMAX(0x7F800001, 0x7FC00000) -> 0x7FC00000, nv 1.
- Backpressure: issue 4 back-to-back ops, drive ready_i=0 for cycles 3-6.
  - ready_o drops after 2 ops are held.
  - result_o is stable while stalled.
  - All 4 results emerge in order once ready_i=1, none dropped or duplicated.
- Reset: assert rst one cycle while 2 ops are in flight -> valid_o=0 and result_o=0 next cycle, no stale result later. A reserved op=6 then yields result 0, nv 0 at 2-cycle latency.
